// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
//   Shared types and helpers for the bit-serial adder sequencer.
//   - sa_state_t : sequencer FSM states (IDLE, RUN, DONE)
//   - sa_ovf     : signed-overflow rule from the carries around the MSB
// -----------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    // Two's-complement overflow: the carry into the MSB differs from the
    // carry out of it.
    function automatic logic sa_ovf(input logic carry_into_msb,
                                    input logic carry_out_msb);
        return carry_into_msb ^ carry_out_msb;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//   Bundles the operand handshake (in_valid/in_ready, a, b, cin) and the result
//   handshake (out_valid/out_ready, sum, cout, ovf) plus the busy status.
//   master : producer of operands / consumer of results (testbench side)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, busy
    );
endinterface

// File: rtl/full_adder_1b.sv
// -----------------------------------------------------------------------------
// full_adder_1b
//   Single combinational 1-bit full adder cell shared by every bit position.
//   i_a, i_b, i_cin : addend bits and carry in
//   o_sum, o_carry  : sum bit and carry out
// -----------------------------------------------------------------------------
module full_adder_1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);
    assign o_sum   = i_a ^ i_b ^ i_cin;
    assign o_carry = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder sequencer. Captures a/b/cin on an accepted operand
//   handshake, then feeds one full-adder cell LSB-first, one bit per clock,
//   for WIDTH cycles. The result (sum, cout, signed ovf) is then presented on
//   the result handshake and held until the consumer takes it.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset, clears all state
//   bus  : slave side of serial_add_ctrl_if (handshakes, operands, result, busy)
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);
    localparam int                CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    sa_state_t          r_state;
    sa_state_t          w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;

    logic               w_fa_sum;
    logic               w_fa_carry;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH:0]     w_sum_shift;

    full_adder_1b u_fa (
        .i_a     (r_a_sh[0]),
        .i_b     (r_b_sh[0]),
        .i_cin   (r_carry),
        .o_sum   (w_fa_sum),
        .o_carry (w_fa_carry)
    );

    assign w_accept    = bus.in_valid && (r_state == IDLE);
    assign w_last      = (r_state == RUN) && (r_cnt == LAST);
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // Written as a concatenate-and-drop so WIDTH=1 needs no special case.
    assign w_sum_shift = {w_fa_sum, r_sum};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid) w_next = RUN;
            RUN:     if (r_cnt == LAST) w_next = DONE;
            DONE:    if (bus.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Serial datapath: operand capture, one bit per RUN cycle, result latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_sum   <= w_sum_shift[WIDTH:1];
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_carry <= w_fa_carry;
            // Counter ends at WIDTH, which CNT_W bits can hold, so it never wraps.
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cout <= w_fa_carry;
                r_ovf  <= sa_ovf(r_carry, w_fa_carry);
            end
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.busy      = (r_state == RUN);
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule
